// File: rtl/cpu_bus_arbiter.sv
// cpu_bus_arbiter: arbitrates N_CH requesters onto a single-outstanding CPU bus.
// Flow: IDLE picks a winner and latches its fields, ISSUE strobes o_bus_DV for
// one cycle, WAIT holds until the slave answers or the timeout expires.
module cpu_bus_arbiter #(
  parameter int N_CH       = 2,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int TIMEOUT    = 255,
  parameter int FIXED_PRIO = 0
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [N_CH-1:0]          i_req_valid,
  input  logic [N_CH*ADDR_W-1:0]   i_req_addr,
  input  logic [N_CH*DATA_W-1:0]   i_req_data,
  input  logic [N_CH*3-1:0]        i_req_bhw,
  input  logic [N_CH-1:0]          i_req_write,
  output logic [N_CH-1:0]          o_req_done,
  output logic [N_CH-1:0]          o_req_err,
  output logic [DATA_W-1:0]        o_rdata,
  output logic [N_CH-1:0]          o_grant,
  output logic                     o_busy,
  output logic [ADDR_W-1:0]        o_bus_address,
  output logic [DATA_W-1:0]        o_bus_data,
  output logic [2:0]               o_bhw,
  output logic                     o_write_notread,
  output logic                     o_bus_DV,
  input  logic [DATA_W-1:0]        i_bus_data,
  input  logic                     i_bus_DV
);

  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // Counter value in the last cycle before the timeout fires.
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [N_CH-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]  last_q,  last_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic [2:0]        bhw_q,   bhw_d;
  logic              write_q, write_d;
  logic [N_CH-1:0]   done_q,  done_d;
  logic [N_CH-1:0]   err_q,   err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  // Per-channel views of the flattened request buses.
  logic [ADDR_W-1:0] req_addr [N_CH];
  logic [DATA_W-1:0] req_data [N_CH];
  logic [2:0]        req_bhw  [N_CH];

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_unpack
      assign req_addr[gi] = i_req_addr[gi*ADDR_W +: ADDR_W];
      assign req_data[gi] = i_req_data[gi*DATA_W +: DATA_W];
      assign req_bhw[gi]  = i_req_bhw[gi*3 +: 3];
    end
  endgenerate

  // Channel index 'off' positions after 'last', wrapping past N_CH-1 to 0.
  function automatic logic [IDX_W-1:0] rr_cand(input logic [IDX_W-1:0] last, input int off);
    int c;
    c = int'(last) + off;
    if (c >= N_CH) c = c - N_CH;
    return IDX_W'(c);
  endfunction

  logic [N_CH-1:0]  eligible;
  logic             win_found;
  logic [IDX_W-1:0] win_idx;

  // Winner selection; a channel receiving its done pulse this cycle sits out.
  always_comb begin
    eligible  = i_req_valid & ~done_q;
    win_found = 1'b0;
    win_idx   = '0;
    if (FIXED_PRIO != 0) begin
      // Scan high to low so the lowest eligible index is the last one kept.
      for (int i = N_CH - 1; i >= 0; i--) begin
        if (eligible[i]) begin
          win_found = 1'b1;
          win_idx   = IDX_W'(i);
        end
      end
    end else begin
      // Scan farthest to nearest from last grant so the nearest one is kept.
      for (int off = N_CH; off >= 1; off--) begin
        if (eligible[rr_cand(last_q, off)]) begin
          win_found = 1'b1;
          win_idx   = rr_cand(last_q, off);
        end
      end
    end
  end

  // Next-state and transaction bookkeeping for IDLE / ISSUE / WAIT.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    bhw_d   = bhw_q;
    write_d = write_q;
    done_d  = '0;
    err_d   = '0;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        // Slave strobes arriving here belong to nobody and are dropped.
        if (win_found) begin
          state_d          = ST_ISSUE;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          last_d           = win_idx;
          cnt_d            = '0;
          addr_d           = req_addr[win_idx];
          data_d           = req_data[win_idx];
          bhw_d            = req_bhw[win_idx];
          write_d          = i_req_write[win_idx];
        end
      end
      ST_ISSUE, ST_WAIT: begin
        state_d = ST_WAIT;
        cnt_d   = cnt_q + CNT_W'(1);
        // A response in the final cycle still wins over the timeout.
        if (i_bus_DV) begin
          done_d  = grant_q;
          rdata_d = write_q ? '0 : i_bus_data;
          grant_d = '0;
          state_d = ST_IDLE;
        end else if ((TIMEOUT > 0) && (cnt_q == CNT_LAST)) begin
          done_d  = grant_q;
          err_d   = grant_q;
          rdata_d = '0;
          grant_d = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset leaves last_q so channel 0 wins first.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(N_CH - 1);
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      bhw_q   <= '0;
      write_q <= 1'b0;
      done_q  <= '0;
      err_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      bhw_q   <= bhw_d;
      write_q <= write_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign o_req_done      = done_q;
  assign o_req_err       = err_q;
  assign o_rdata         = rdata_q;
  assign o_grant         = grant_q;
  assign o_busy          = (state_q != ST_IDLE);
  assign o_bus_DV        = (state_q == ST_ISSUE);
  assign o_bus_address   = addr_q;
  assign o_bus_data      = data_q;
  assign o_bhw           = bhw_q;
  assign o_write_notread = write_q;

  // Ownership and completion are always exclusive to a single channel.
  assert property (@(posedge i_clk) disable iff (i_rst) $onehot0(grant_q));
  assert property (@(posedge i_clk) disable iff (i_rst) $onehot0(done_q));

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// tb_cpu_bus_arbiter: directed checks of a round-robin instance (A) and a
// fixed-priority instance (B), both 3 channels with a 4-cycle timeout.
module tb_cpu_bus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Instance A: round robin
  logic        a_rst;
  logic [2:0]  a_valid, a_write;
  logic [95:0] a_addr, a_wdata;
  logic [8:0]  a_bhw;
  logic [31:0] a_sdata;
  logic        a_sdv;
  logic [2:0]  a_done, a_err, a_grant, a_bbhw;
  logic [31:0] a_rdata, a_baddr, a_bdata;
  logic        a_busy, a_bwr, a_bdv;

  // Instance B: fixed priority
  logic        b_rst;
  logic [2:0]  b_valid, b_write;
  logic [95:0] b_addr, b_wdata;
  logic [8:0]  b_bhw;
  logic [31:0] b_sdata;
  logic        b_sdv;
  logic [2:0]  b_done, b_err, b_grant, b_bbhw;
  logic [31:0] b_rdata, b_baddr, b_bdata;
  logic        b_busy, b_bwr, b_bdv;

  logic [2:0] rr_exp [6];

  cpu_bus_arbiter #(.N_CH(3), .ADDR_W(32), .DATA_W(32), .TIMEOUT(4), .FIXED_PRIO(0)) dut_a (
    .i_clk(clk), .i_rst(a_rst), .i_req_valid(a_valid), .i_req_addr(a_addr),
    .i_req_data(a_wdata), .i_req_bhw(a_bhw), .i_req_write(a_write),
    .o_req_done(a_done), .o_req_err(a_err), .o_rdata(a_rdata), .o_grant(a_grant),
    .o_busy(a_busy), .o_bus_address(a_baddr), .o_bus_data(a_bdata), .o_bhw(a_bbhw),
    .o_write_notread(a_bwr), .o_bus_DV(a_bdv), .i_bus_data(a_sdata), .i_bus_DV(a_sdv)
  );

  cpu_bus_arbiter #(.N_CH(3), .ADDR_W(32), .DATA_W(32), .TIMEOUT(4), .FIXED_PRIO(1)) dut_b (
    .i_clk(clk), .i_rst(b_rst), .i_req_valid(b_valid), .i_req_addr(b_addr),
    .i_req_data(b_wdata), .i_req_bhw(b_bhw), .i_req_write(b_write),
    .o_req_done(b_done), .o_req_err(b_err), .o_rdata(b_rdata), .o_grant(b_grant),
    .o_busy(b_busy), .o_bus_address(b_baddr), .o_bus_data(b_bdata), .o_bhw(b_bbhw),
    .o_write_notread(b_bwr), .o_bus_DV(b_bdv), .i_bus_data(b_sdata), .i_bus_DV(b_sdv)
  );

  task automatic reset_a();
    a_rst = 1'b1; a_valid = '0; a_write = '0; a_addr = '0; a_wdata = '0;
    a_bhw = '0; a_sdv = 1'b0; a_sdata = '0;
    @(negedge clk); @(negedge clk);
    a_rst = 1'b0;
  endtask

  task automatic reset_b();
    b_rst = 1'b1; b_valid = '0; b_write = '0; b_addr = '0; b_wdata = '0;
    b_bhw = '0; b_sdv = 1'b0; b_sdata = '0;
    @(negedge clk); @(negedge clk);
    b_rst = 1'b0;
  endtask

  task automatic test_reset();
    reset_a();
    n_cmp++; if (a_done !== 3'b000) begin n_bad++; $display("FAIL rst_done: got %b want 000", a_done); end
    n_cmp++; if (a_err !== 3'b000) begin n_bad++; $display("FAIL rst_err: got %b want 000", a_err); end
    n_cmp++; if (a_grant !== 3'b000) begin n_bad++; $display("FAIL rst_grant: got %b want 000", a_grant); end
    n_cmp++; if (a_busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", a_busy); end
    n_cmp++; if (a_bdv !== 1'b0) begin n_bad++; $display("FAIL rst_bus_dv: got %b want 0", a_bdv); end
    n_cmp++; if ({a_rdata, a_baddr, a_bdata, a_bbhw, a_bwr} !== 100'd0) begin
      n_bad++; $display("FAIL rst_fields: got %h/%h/%h/%b/%b want all 0", a_rdata, a_baddr, a_bdata, a_bbhw, a_bwr);
    end
    // Stray slave strobe while idle must leave no trace.
    a_sdv = 1'b1; a_sdata = 32'h0000_0055;
    @(negedge clk);
    a_sdv = 1'b0;
    @(negedge clk);
    n_cmp++; if (a_done !== 3'b000) begin n_bad++; $display("FAIL idle_dv_done: got %b want 000", a_done); end
    n_cmp++; if (a_rdata !== 32'h0) begin n_bad++; $display("FAIL idle_dv_rdata: got %h want 0", a_rdata); end
    n_cmp++; if (a_busy !== 1'b0) begin n_bad++; $display("FAIL idle_dv_busy: got %b want 0", a_busy); end
  endtask

  task automatic test_single_read();
    reset_a();
    a_addr[31:0] = 32'h0000_0100; a_write = 3'b000; a_valid = 3'b001;
    @(negedge clk);
    n_cmp++; if (a_bdv !== 1'b1) begin n_bad++; $display("FAIL rd_strobe: got %b want 1", a_bdv); end
    n_cmp++; if (a_grant !== 3'b001) begin n_bad++; $display("FAIL rd_grant: got %b want 001", a_grant); end
    n_cmp++; if (a_baddr !== 32'h100) begin n_bad++; $display("FAIL rd_addr: got %h want 00000100", a_baddr); end
    n_cmp++; if (a_bwr !== 1'b0) begin n_bad++; $display("FAIL rd_wnr: got %b want 0", a_bwr); end
    @(negedge clk);
    n_cmp++; if ({a_bdv, a_busy} !== 2'b01) begin n_bad++; $display("FAIL rd_wait: got dv,busy=%b want 01", {a_bdv, a_busy}); end
    @(negedge clk);
    n_cmp++; if (a_done !== 3'b000) begin n_bad++; $display("FAIL rd_early_done: got %b want 000", a_done); end
    a_sdv = 1'b1; a_sdata = 32'hDEAD_BEEF;
    @(negedge clk);
    a_sdv = 1'b0; a_valid = 3'b000;
    $display("txn read ch0 addr=%h done=%b err=%b rdata=%h", a_baddr, a_done, a_err, a_rdata);
    n_cmp++; if (a_done !== 3'b001) begin n_bad++; $display("FAIL rd_done: got %b want 001", a_done); end
    n_cmp++; if (a_err !== 3'b000) begin n_bad++; $display("FAIL rd_err: got %b want 000", a_err); end
    n_cmp++; if (a_rdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL rd_rdata: got %h want deadbeef", a_rdata); end
    n_cmp++; if ({a_grant, a_busy} !== 4'b0000) begin n_bad++; $display("FAIL rd_release: got grant,busy=%b want 0000", {a_grant, a_busy}); end
    @(negedge clk);
    n_cmp++; if (a_done !== 3'b000) begin n_bad++; $display("FAIL rd_done_pulse: got %b want 000", a_done); end
  endtask

  task automatic test_write();
    reset_a();
    a_addr[63:32] = 32'h0000_0200; a_wdata[63:32] = 32'h1234_5678;
    a_bhw[5:3] = 3'b010; a_write = 3'b010; a_valid = 3'b010;
    @(negedge clk);
    n_cmp++; if ({a_bdv, a_grant} !== 4'b1010) begin n_bad++; $display("FAIL wr_issue: got dv,grant=%b want 1010", {a_bdv, a_grant}); end
    // Requester fields change after grant; the bus must not follow.
    a_addr[63:32] = 32'hFFFF_0000; a_wdata[63:32] = 32'h0; a_bhw[5:3] = 3'b111; a_write = 3'b000;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if ({a_baddr, a_bdata, a_bbhw, a_bwr} !== {32'h200, 32'h1234_5678, 3'b010, 1'b1}) begin
        n_bad++; $display("FAIL wr_fields_c%0d: got %h/%h/%b/%b want 00000200/12345678/010/1", i, a_baddr, a_bdata, a_bbhw, a_bwr);
      end
      if (i < 2) @(negedge clk);
    end
    a_sdv = 1'b1; a_sdata = 32'hCAFE_F00D;
    @(negedge clk);
    a_sdv = 1'b0; a_valid = 3'b000;
    $display("txn write ch1 addr=%h data=%h done=%b rdata=%h", a_baddr, a_bdata, a_done, a_rdata);
    n_cmp++; if ({a_done, a_err} !== 6'b010_000) begin n_bad++; $display("FAIL wr_done: got done,err=%b want 010000", {a_done, a_err}); end
    n_cmp++; if (a_rdata !== 32'h0) begin n_bad++; $display("FAIL wr_rdata: got %h want 0", a_rdata); end
    n_cmp++; if ({a_baddr, a_bdata, a_bbhw, a_bwr} !== {32'h200, 32'h1234_5678, 3'b010, 1'b1}) begin
      n_bad++; $display("FAIL wr_fields_done: got %h/%h/%b/%b want 00000200/12345678/010/1", a_baddr, a_bdata, a_bbhw, a_bwr);
    end
  endtask

  task automatic test_round_robin();
    int   got;
    logic prev_dv;
    reset_a();
    got = 0; prev_dv = 1'b0;
    a_valid = 3'b111;
    // Slave answers one cycle after each strobe; bounded cycle budget.
    for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
      @(negedge clk);
      if (a_bdv) begin
        $display("txn rr grant#%0d grant=%b", got, a_grant);
        n_cmp++; if (a_grant !== rr_exp[got]) begin n_bad++; $display("FAIL rr_grant%0d: got %b want %b", got, a_grant, rr_exp[got]); end
        got++;
      end
      a_sdv = prev_dv; a_sdata = 32'h1000 + cyc;
      prev_dv = a_bdv;
    end
    a_valid = 3'b000; a_sdv = 1'b0;
    n_cmp++; if (got != 6) begin n_bad++; $display("FAIL rr_count: got %0d grants want 6", got); end
  endtask

  task automatic test_timeout();
    reset_a();
    // Prime o_rdata with a nonzero value so the timeout clear is visible.
    a_valid = 3'b010;
    @(negedge clk);
    a_sdv = 1'b1; a_sdata = 32'hA5A5_A5A5;
    @(negedge clk);
    a_sdv = 1'b0; a_valid = 3'b001;
    n_cmp++; if ({a_done, a_rdata} !== {3'b010, 32'hA5A5_A5A5}) begin n_bad++; $display("FAIL to_prime: got %b/%h want 010/a5a5a5a5", a_done, a_rdata); end
    @(negedge clk);
    n_cmp++; if ({a_bdv, a_grant} !== 4'b1001) begin n_bad++; $display("FAIL to_issue: got dv,grant=%b want 1001", {a_bdv, a_grant}); end
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      n_cmp++; if ({a_done, a_busy} !== 4'b0001) begin n_bad++; $display("FAIL to_wait%0d: got done,busy=%b want 0001", i, {a_done, a_busy}); end
    end
    @(negedge clk);
    a_valid = 3'b000;
    $display("txn timeout ch0 done=%b err=%b rdata=%h", a_done, a_err, a_rdata);
    n_cmp++; if ({a_done, a_err} !== 6'b001_001) begin n_bad++; $display("FAIL to_fire: got done,err=%b want 001001", {a_done, a_err}); end
    n_cmp++; if (a_rdata !== 32'h0) begin n_bad++; $display("FAIL to_rdata: got %h want 0", a_rdata); end
    n_cmp++; if ({a_grant, a_busy} !== 4'b0000) begin n_bad++; $display("FAIL to_release: got %b want 0000", {a_grant, a_busy}); end
    @(negedge clk);
    n_cmp++; if ({a_done, a_err} !== 6'b0) begin n_bad++; $display("FAIL to_pulse: got %b want 000000", {a_done, a_err}); end
    // Response in the very cycle the counter hits the limit: success.
    a_valid = 3'b001;
    @(negedge clk);
    n_cmp++; if (a_bdv !== 1'b1) begin n_bad++; $display("FAIL to2_issue: got %b want 1", a_bdv); end
    @(negedge clk); @(negedge clk); @(negedge clk);
    a_sdv = 1'b1; a_sdata = 32'h0BAD_F00D;
    @(negedge clk);
    a_sdv = 1'b0; a_valid = 3'b000;
    $display("txn late-read ch0 done=%b err=%b rdata=%h", a_done, a_err, a_rdata);
    n_cmp++; if ({a_done, a_err} !== 6'b001_000) begin n_bad++; $display("FAIL to2_done: got done,err=%b want 001000", {a_done, a_err}); end
    n_cmp++; if (a_rdata !== 32'h0BAD_F00D) begin n_bad++; $display("FAIL to2_rdata: got %h want 0badf00d", a_rdata); end
  endtask

  task automatic test_reset_mid_wait();
    reset_a();
    a_addr[63:32] = 32'h0000_0300; a_valid = 3'b010;
    @(negedge clk);
    n_cmp++; if (a_grant !== 3'b010) begin n_bad++; $display("FAIL rw_grant: got %b want 010", a_grant); end
    @(negedge clk);
    n_cmp++; if ({a_bdv, a_busy} !== 2'b01) begin n_bad++; $display("FAIL rw_in_wait: got %b want 01", {a_bdv, a_busy}); end
    a_rst = 1'b1; a_valid = 3'b000;
    @(negedge clk);
    a_rst = 1'b0; a_sdv = 1'b1; a_sdata = 32'h7777_7777;
    n_cmp++; if ({a_busy, a_bdv, a_grant, a_done, a_err, a_baddr, a_rdata} !== 75'd0) begin
      n_bad++; $display("FAIL rw_cleared: got busy=%b dv=%b grant=%b done=%b err=%b addr=%h rdata=%h want all 0", a_busy, a_bdv, a_grant, a_done, a_err, a_baddr, a_rdata);
    end
    @(negedge clk);
    a_sdv = 1'b0;
    n_cmp++; if ({a_done, a_err, a_busy} !== 7'd0) begin n_bad++; $display("FAIL rw_no_done: got %b want 0000000", {a_done, a_err, a_busy}); end
    n_cmp++; if (a_rdata !== 32'h0) begin n_bad++; $display("FAIL rw_rdata: got %h want 0", a_rdata); end
    // Last grant was ch1; only a reset pointer makes ch0 beat ch2 here.
    a_addr[31:0] = 32'h0000_0400; a_addr[95:64] = 32'h0000_0500; a_valid = 3'b101;
    @(negedge clk);
    n_cmp++; if ({a_grant, a_baddr} !== {3'b001, 32'h400}) begin n_bad++; $display("FAIL rw_next: got grant=%b addr=%h want 001/00000400", a_grant, a_baddr); end
    a_sdv = 1'b1; a_sdata = 32'h0000_0011;
    @(negedge clk);
    a_sdv = 1'b0; a_valid = 3'b000;
    $display("txn post-reset ch0 done=%b rdata=%h", a_done, a_rdata);
    n_cmp++; if (a_done !== 3'b001) begin n_bad++; $display("FAIL rw_next_done: got %b want 001", a_done); end
  endtask

  task automatic test_back_to_back();
    reset_a();
    a_valid = 3'b001;
    @(negedge clk);
    a_sdv = 1'b1; a_sdata = 32'h0000_0001;
    @(negedge clk);
    a_sdv = 1'b0;
    $display("txn b2b#0 ch0 done=%b", a_done);
    n_cmp++; if (a_done !== 3'b001) begin n_bad++; $display("FAIL b2b_done0: got %b want 001", a_done); end
    // ch0 keeps valid through its own done cycle and must sit that cycle out.
    @(negedge clk);
    n_cmp++; if ({a_bdv, a_busy} !== 2'b00) begin n_bad++; $display("FAIL b2b_masked: got dv,busy=%b want 00", {a_bdv, a_busy}); end
    @(negedge clk);
    n_cmp++; if ({a_bdv, a_grant} !== 4'b1001) begin n_bad++; $display("FAIL b2b_regrant: got %b want 1001", {a_bdv, a_grant}); end
    a_sdv = 1'b1; a_sdata = 32'h0000_0002;
    @(negedge clk);
    a_sdv = 1'b0; a_valid = 3'b000;
    $display("txn b2b#1 ch0 done=%b rdata=%h", a_done, a_rdata);
    n_cmp++; if ({a_done, a_rdata} !== {3'b001, 32'h2}) begin n_bad++; $display("FAIL b2b_done1: got %b/%h want 001/00000002", a_done, a_rdata); end
  endtask

  task automatic test_fixed_priority();
    reset_b();
    b_valid = 3'b010;
    @(negedge clk);
    n_cmp++; if (b_grant !== 3'b010) begin n_bad++; $display("FAIL fp_ch1: got %b want 010", b_grant); end
    b_sdv = 1'b1;
    @(negedge clk);
    b_sdv = 1'b0; b_valid = 3'b000;
    @(negedge clk);
    // After a ch1 grant round robin would choose ch2; fixed priority picks ch0.
    b_valid = 3'b101;
    @(negedge clk);
    $display("txn fp ch0+ch2 requested grant=%b", b_grant);
    n_cmp++; if (b_grant !== 3'b001) begin n_bad++; $display("FAIL fp_ch0_over_ch2: got %b want 001", b_grant); end
    b_sdv = 1'b1; b_sdata = 32'h0000_00C0;
    @(negedge clk);
    b_sdv = 1'b0; b_valid = 3'b100;
    n_cmp++; if (b_done !== 3'b001) begin n_bad++; $display("FAIL fp_ch0_done: got %b want 001", b_done); end
    @(negedge clk);
    $display("txn fp ch0 dropped grant=%b", b_grant);
    n_cmp++; if ({b_bdv, b_grant} !== 4'b1100) begin n_bad++; $display("FAIL fp_ch2_after: got dv,grant=%b want 1100", {b_bdv, b_grant}); end
    b_sdv = 1'b1; b_sdata = 32'h0000_00C2;
    @(negedge clk);
    b_sdv = 1'b0; b_valid = 3'b000;
    n_cmp++; if ({b_done, b_rdata} !== {3'b100, 32'hC2}) begin n_bad++; $display("FAIL fp_ch2_done: got %b/%h want 100/000000c2", b_done, b_rdata); end
    @(negedge clk);
    b_valid = 3'b110;
    @(negedge clk);
    $display("txn fp ch1+ch2 requested grant=%b", b_grant);
    n_cmp++; if (b_grant !== 3'b010) begin n_bad++; $display("FAIL fp_lowest: got %b want 010", b_grant); end
    b_sdv = 1'b1;
    @(negedge clk);
    b_sdv = 1'b0; b_valid = 3'b000;
  endtask

  // Hard stop in case something above stalls.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rr_exp[0] = 3'b001; rr_exp[1] = 3'b010; rr_exp[2] = 3'b100;
    rr_exp[3] = 3'b001; rr_exp[4] = 3'b010; rr_exp[5] = 3'b100;
    a_rst = 1'b1; a_valid = '0; a_write = '0; a_addr = '0; a_wdata = '0; a_bhw = '0; a_sdv = 1'b0; a_sdata = '0;
    b_rst = 1'b1; b_valid = '0; b_write = '0; b_addr = '0; b_wdata = '0; b_bhw = '0; b_sdv = 1'b0; b_sdata = '0;
    @(negedge clk);
    test_reset();
    test_single_read();
    test_write();
    test_round_robin();
    test_timeout();
    test_reset_mid_wait();
    test_back_to_back();
    test_fixed_priority();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
